// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file sizing constants.
package rf_pkg;
  localparam int DATA_W = 32;
  localparam int NUM_REGS = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] X0_ADDR = 5'd0;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: pending-destination busy bits and source-operand hazard detection.
module rf_scoreboard #(
  parameter int NUM_REGS = rf_pkg::NUM_REGS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [rf_pkg::REG_ADDR_W-1:0] rd_addr_1_i,
  input  logic [rf_pkg::REG_ADDR_W-1:0] rd_addr_2_i,
  input  logic [rf_pkg::REG_ADDR_W-1:0] wr_addr_i,
  input  logic                          wr_en_i,
  input  logic [rf_pkg::REG_ADDR_W-1:0] rsv_addr_i,
  input  logic                          rsv_en_i,
  output logic                          stall_o
);
  import rf_pkg::*;
  logic [NUM_REGS-1:0] busy_q, busy_d, wr_clr, rsv_set;
  logic hz_1, hz_2;
  // A write-back in flight resolves the hazard in the same cycle via the bypass.
  always_comb begin
    hz_1 = busy_q[rd_addr_1_i] && !(wr_en_i && wr_addr_i == rd_addr_1_i);
    hz_2 = busy_q[rd_addr_2_i] && !(wr_en_i && wr_addr_i == rd_addr_2_i);
    stall_o = hz_1 || hz_2;
    wr_clr = wr_en_i ? NUM_REGS'(1) << wr_addr_i : '0;
    rsv_set = (rsv_en_i && !stall_o && rsv_addr_i != X0_ADDR) ? NUM_REGS'(1) << rsv_addr_i : '0;
    busy_d = ((busy_q & ~wr_clr) | rsv_set) & {{(NUM_REGS-1){1'b1}}, 1'b0};
  end
  always_ff @(posedge clk) busy_q <= rst ? '0 : busy_d;
endmodule

// File: rtl/reg_file_core.sv
// reg_file_core: two-read/one-write register file with write-through bypass and x0 hardwired to zero.
module reg_file_core #(
  parameter int DATA_W = rf_pkg::DATA_W,
  parameter int NUM_REGS = rf_pkg::NUM_REGS
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [31:0]                   READ_Addr_1,
  input  logic [31:0]                   READ_Addr_2,
  input  logic [DATA_W-1:0]             WRITE_Data,
  input  logic [rf_pkg::REG_ADDR_W-1:0] WRITE_Addr,
  input  logic                          WRITE_En,
  input  logic [rf_pkg::REG_ADDR_W-1:0] RSV_Addr,
  input  logic                          RSV_En,
  output logic [DATA_W-1:0]             READ_Data_1,
  output logic [DATA_W-1:0]             READ_Data_2,
  output logic                          STALL
);
  import rf_pkg::*;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [REG_ADDR_W-1:0] ra_1, ra_2;
  logic unused_addr_hi;
  assign ra_1 = READ_Addr_1[REG_ADDR_W-1:0];
  assign ra_2 = READ_Addr_2[REG_ADDR_W-1:0];
  assign unused_addr_hi = ^{READ_Addr_1[31:REG_ADDR_W], READ_Addr_2[31:REG_ADDR_W]};
  function automatic logic [DATA_W-1:0] rd_mux(input logic [REG_ADDR_W-1:0] a);
    return a == X0_ADDR ? '0 : (WRITE_En && WRITE_Addr == a) ? WRITE_Data : regs_q[a];
  endfunction
  always_comb begin
    READ_Data_1 = rd_mux(ra_1);
    READ_Data_2 = rd_mux(ra_2);
  end
  always_ff @(posedge CLK) begin
    if (RST) for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    else if (WRITE_En && WRITE_Addr != X0_ADDR) regs_q[WRITE_Addr] <= WRITE_Data;
  end
  rf_scoreboard #(.NUM_REGS(NUM_REGS)) u_sb (
    .clk(CLK),
    .rst(RST),
    .rd_addr_1_i(ra_1),
    .rd_addr_2_i(ra_2),
    .wr_addr_i(WRITE_Addr),
    .wr_en_i(WRITE_En),
    .rsv_addr_i(RSV_Addr),
    .rsv_en_i(RSV_En),
    .stall_o(STALL)
  );
endmodule
